// File: rtl/n64_pkg.sv
// ---------------------------------------------------------------------------
// n64_pkg
// Shared types and constants for the N64 paddle tracker.
//   n64_status_t     : 32-bit controller status word, MSB first
//   BTN_*_BIT        : bit positions of the digital buttons in the status word
//   tracker_state_t  : poll/response state machine encoding
//   abs9()           : magnitude of a signed 8-bit axis, widened so -128 -> 128
// ---------------------------------------------------------------------------
package n64_pkg;

   typedef struct packed {
      logic              a;       // [31]
      logic              b;       // [30]
      logic              z;       // [29]
      logic              start;   // [28]
      logic              up;      // [27]
      logic              down;    // [26]
      logic              left;    // [25]
      logic              right;   // [24]
      logic [7:0]        aux;     // [23:16] shoulder / C buttons, passed through
      logic signed [7:0] x;       // [15:8]
      logic signed [7:0] y;       // [7:0]
   } n64_status_t;

   localparam int BTN_A_BIT     = 31;
   localparam int BTN_B_BIT     = 30;
   localparam int BTN_Z_BIT     = 29;
   localparam int BTN_START_BIT = 28;
   localparam int BTN_UP_BIT    = 27;
   localparam int BTN_DOWN_BIT  = 26;
   localparam int BTN_LEFT_BIT  = 25;
   localparam int BTN_RIGHT_BIT = 24;

   // The buttons output carries status[31:16]; offset to index into it.
   localparam int BUTTONS_LSB   = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_RESP = 2'd1,
      UPDATE    = 2'd2
   } tracker_state_t;

   // Absolute value in 9 bits so that -128 does not wrap back to -128.
   function automatic logic [8:0] abs9(input logic signed [7:0] v);
      logic signed [8:0] w;
      w = {v[7], v};
      return w[8] ? $unsigned(-w) : $unsigned(w);
   endfunction

endpackage

// File: rtl/n64_stick_stepper.sv
// ---------------------------------------------------------------------------
// n64_stick_stepper
// Combinational conversion of joystick Y and D-pad Up/Down into a signed
// paddle step.
//   y_i     in  8       signed joystick Y (+Y moves the paddle up/positive)
//   up_i    in  1       D-pad Up held
//   down_i  in  1       D-pad Down held
//   step_o  out STEP_W  signed step to add to the paddle position
// The joystick has priority; the D-pad only acts when the stick produces
// no movement (inside the deadzone).
// ---------------------------------------------------------------------------
module n64_stick_stepper
   import n64_pkg::*;
#(
   parameter int DEADZONE    = 8,
   parameter int SPEED_SHIFT = 3,
   parameter int DPAD_STEP   = 2,
   parameter int STEP_W      = 11
) (
   input  logic signed [7:0]        y_i,
   input  logic                     up_i,
   input  logic                     down_i,
   output logic signed [STEP_W-1:0] step_o
);

   logic [8:0] mag;
   logic [8:0] excess;
   logic [8:0] js_mag;

   always_comb begin
      mag    = abs9(y_i);
      excess = mag - 9'(DEADZONE);
      js_mag = 9'd0;
      if (mag > 9'(DEADZONE)) begin
         js_mag = excess >> SPEED_SHIFT;
         // Any deflection past the deadzone moves at least one unit, so the
         // slow band just outside the deadzone is not dead.
         if (js_mag == 9'd0) begin
            js_mag = 9'd1;
         end
      end

      step_o = '0;
      if (js_mag != 9'd0) begin
         step_o = y_i[7] ? -STEP_W'(js_mag) : STEP_W'(js_mag);
      end else if (up_i && !down_i) begin
         step_o = STEP_W'(DPAD_STEP);
      end else if (down_i && !up_i) begin
         step_o = -STEP_W'(DPAD_STEP);
      end
   end

endmodule

// File: rtl/n64_paddle_tracker.sv
// ---------------------------------------------------------------------------
// n64_paddle_tracker
// Polls an N64 controller interface on a fixed period, captures each
// response and turns it into a saturating paddle position plus button events.
//   clk              in   1      system clock
//   reset            in   1      synchronous active-high reset
//   enable           in   1      permits new polls
//   poll_start       out  1      start request to the controller interface
//   ctrl_data        in   34     response; [31:0] status word, [33:32] unused
//   ctrl_read_valid  in   1      response valid (level; rising edge used)
//   paddle_pos       out  POS_W  paddle position, 0..PADDLE_MAX
//   buttons          out  16     last captured status[31:16]
//   sample_valid     out  1      one-cycle pulse when outputs update
//   serve_pulse      out  1      one-cycle pulse on an A press (not paused)
//   pause            out  1      toggled by Start presses
//   stale            out  1      last poll timed out
//   timeout_count    out  8      saturating count of timeouts
// ---------------------------------------------------------------------------
module n64_paddle_tracker
   import n64_pkg::*;
#(
   parameter int POLL_PERIOD    = 1000,
   parameter int START_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 800,
   parameter int POS_W          = 9,
   parameter int PADDLE_MAX     = 400,
   parameter int DEADZONE       = 8,
   parameter int SPEED_SHIFT    = 3,
   parameter int DPAD_STEP      = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   output logic             poll_start,
   input  logic [33:0]      ctrl_data,
   input  logic             ctrl_read_valid,
   output logic [POS_W-1:0] paddle_pos,
   output logic [15:0]      buttons,
   output logic             sample_valid,
   output logic             serve_pulse,
   output logic             pause,
   output logic             stale,
   output logic [7:0]       timeout_count
);

   localparam int PCW    = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
   localparam int WCW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam int SCW    = $clog2(START_CYCLES + 1);
   localparam int STEP_W = POS_W + 2;

   localparam logic signed [STEP_W-1:0] POS_MAX_S = STEP_W'(PADDLE_MAX);

   // ---------------- state ----------------
   tracker_state_t   state_q, state_d;
   logic [PCW-1:0]   cnt_q, cnt_d;
   logic [WCW-1:0]   wait_q, wait_d;
   logic [SCW-1:0]   start_q, start_d;
   logic             rv_prev_q;
   n64_status_t      status_q, status_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [15:0]      buttons_q, buttons_d;
   logic             sample_valid_q, sample_valid_d;
   logic             serve_q, serve_d;
   logic             pause_q, pause_d;
   logic             stale_q, stale_d;
   logic [7:0]       tcount_q, tcount_d;

   // ---------------- combinational helpers ----------------
   logic                     tick;
   logic                     rise;
   logic                     a_rise;
   logic                     start_rise;
   logic signed [STEP_W-1:0] step;
   logic signed [STEP_W-1:0] sum;
   logic [POS_W-1:0]         clamped;

   n64_stick_stepper #(
      .DEADZONE    (DEADZONE),
      .SPEED_SHIFT (SPEED_SHIFT),
      .DPAD_STEP   (DPAD_STEP),
      .STEP_W      (STEP_W)
   ) u_stepper (
      .y_i    (status_q.y),
      .up_i   (status_q.up),
      .down_i (status_q.down),
      .step_o (step)
   );

   assign tick = (cnt_q == PCW'(POLL_PERIOD - 1));
   assign rise = ctrl_read_valid & ~rv_prev_q;

   // buttons_q holds the previous captured status[31:16], so it doubles as
   // the reference for press detection.
   assign a_rise     = status_q.a     & ~buttons_q[BTN_A_BIT - BUTTONS_LSB];
   assign start_rise = status_q.start & ~buttons_q[BTN_START_BIT - BUTTONS_LSB];

   always_comb begin
      sum = $signed({2'b00, pos_q}) + step;
      if (sum < 0) begin
         clamped = '0;
      end else if (sum > POS_MAX_S) begin
         clamped = POS_W'(PADDLE_MAX);
      end else begin
         clamped = sum[POS_W-1:0];
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d        = state_q;
      cnt_d          = tick ? '0 : cnt_q + PCW'(1);
      wait_d         = wait_q;
      start_d        = start_q;
      status_d       = status_q;
      pos_d          = pos_q;
      buttons_d      = buttons_q;
      sample_valid_d = 1'b0;
      serve_d        = 1'b0;
      pause_d        = pause_q;
      stale_d        = stale_q;
      tcount_d       = tcount_q;

      case (state_q)
         IDLE: begin
            if (tick && enable) begin
               state_d = WAIT_RESP;
               wait_d  = '0;
               start_d = SCW'(START_CYCLES);
            end
         end

         WAIT_RESP: begin
            // Ticks and enable are ignored here: an outstanding poll always
            // runs to a response or a timeout.
            wait_d = wait_q + WCW'(1);
            if (start_q != '0) begin
               start_d = start_q - SCW'(1);
            end
            if (rise) begin
               // A response beats a timeout landing on the same cycle.
               state_d  = UPDATE;
               status_d = n64_status_t'(ctrl_data[31:0]);
               start_d  = '0;
            end else if (wait_q == WCW'(TIMEOUT_CYCLES - 1)) begin
               state_d = IDLE;
               stale_d = 1'b1;
               start_d = '0;
               if (tcount_q != 8'hFF) begin
                  tcount_d = tcount_q + 8'd1;
               end
            end
         end

         UPDATE: begin
            state_d        = IDLE;
            buttons_d      = status_q[31:16];
            sample_valid_d = 1'b1;
            stale_d        = 1'b0;
            // The pause value in force before this sample gates both motion
            // and serving; a Start press only affects later samples.
            if (!pause_q) begin
               pos_d = clamped;
            end
            if (a_rise && !pause_q) begin
               serve_d = 1'b1;
            end
            if (start_rise) begin
               pause_d = ~pause_q;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         wait_q         <= '0;
         start_q        <= '0;
         rv_prev_q      <= 1'b0;
         status_q       <= '0;
         pos_q          <= POS_W'(PADDLE_MAX / 2);
         buttons_q      <= '0;
         sample_valid_q <= 1'b0;
         serve_q        <= 1'b0;
         pause_q        <= 1'b0;
         stale_q        <= 1'b0;
         tcount_q       <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         wait_q         <= wait_d;
         start_q        <= start_d;
         rv_prev_q      <= ctrl_read_valid;
         status_q       <= status_d;
         pos_q          <= pos_d;
         buttons_q      <= buttons_d;
         sample_valid_q <= sample_valid_d;
         serve_q        <= serve_d;
         pause_q        <= pause_d;
         stale_q        <= stale_d;
         tcount_q       <= tcount_d;
      end
   end

   // ---------------- outputs ----------------
   assign poll_start    = (start_q != '0);
   assign paddle_pos    = pos_q;
   assign buttons       = buttons_q;
   assign sample_valid  = sample_valid_q;
   assign serve_pulse   = serve_q;
   assign pause         = pause_q;
   assign stale         = stale_q;
   assign timeout_count = tcount_q;

   // Response framing bits and the X axis are not used by the paddle.
   logic unused_bits;
   assign unused_bits = ^{ctrl_data[33:32], status_q.x};

endmodule

// File: tb/tb_n64_paddle_tracker.sv
// ---------------------------------------------------------------------------
// tb_n64_paddle_tracker
// Table-driven bench for n64_paddle_tracker: each record is one poll with the
// status word to return, the response delay and the hand-computed paddle
// position / serve / pause that must follow. Hand-written sequences cover
// timeout, ignored responses, skipped polls and reset during a poll.
// ---------------------------------------------------------------------------
module tb_n64_paddle_tracker;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        poll_start;
   logic [33:0] ctrl_data;
   logic        ctrl_read_valid;
   logic [8:0]  paddle_pos;
   logic [15:0] buttons;
   logic        sample_valid;
   logic        serve_pulse;
   logic        pause;
   logic        stale;
   logic [7:0]  timeout_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   n64_paddle_tracker dut (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .poll_start      (poll_start),
      .ctrl_data       (ctrl_data),
      .ctrl_read_valid (ctrl_read_valid),
      .paddle_pos      (paddle_pos),
      .buttons         (buttons),
      .sample_valid    (sample_valid),
      .serve_pulse     (serve_pulse),
      .pause           (pause),
      .stale           (stale),
      .timeout_count   (timeout_count)
   );

   typedef struct {
      logic        rst;     // reset before this poll
      logic [31:0] st;      // status word returned
      int          dly;     // cycles after poll_start is first seen
      logic [8:0]  pos;     // expected paddle_pos
      logic        serve;   // expected serve_pulse with sample_valid
      logic        pause;   // expected pause after the sample
   } vec_t;

   vec_t vecs [0:79];
   int   nvec = 0;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mkst(input logic a, input logic st, input logic up,
                                        input logic dn, input int y);
      logic [7:0] yb;
      yb = 8'(y);
      // B held, Right held, aux/X filler so the buttons field is non-trivial.
      return {a, 1'b1, 1'b0, st, up, dn, 2'b01, 8'hA5, 8'h3C, yb};
   endfunction

   task automatic add(input logic rst, input logic [31:0] st, input int dly,
                      input int pos, input logic serve, input logic pse);
      vecs[nvec].rst   = rst;
      vecs[nvec].st    = st;
      vecs[nvec].dly   = dly;
      vecs[nvec].pos   = 9'(pos);
      vecs[nvec].serve = serve;
      vecs[nvec].pause = pse;
      nvec++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset           = 1'b1;
      ctrl_read_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Waits (bounded) for poll_start at a falling edge.
   task automatic wait_poll(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2100; i++) begin
         @(negedge clk);
         if (poll_start) begin
            ok = 1'b1;
            return;
         end
      end
      tests++;
      fails++;
      $display("FAIL poll_start_wait: got no poll_start in 2100 cycles, expected one");
   endtask

   // Answers one poll and returns the outputs seen with sample_valid.
   task automatic do_poll(input logic [31:0] st, input int dly,
                          output logic [8:0] p, output logic s, output logic pa,
                          output logic stl, output logic [15:0] b);
      bit   ok;
      logic sv1;
      p = 'x; s = 'x; pa = 'x; stl = 'x; b = 'x;
      wait_poll(ok);
      if (!ok) return;
      repeat (dly) @(negedge clk);
      ctrl_data       = {2'b11, st};
      ctrl_read_valid = 1'b1;
      @(negedge clk);
      sv1 = sample_valid;
      if (dly == 0) check("start_forced_low", 32'(poll_start), 32'd0);
      @(negedge clk);
      check("latency", 32'({sv1, sample_valid}), 32'd1);
      p   = paddle_pos;
      s   = serve_pulse;
      pa  = pause;
      stl = stale;
      b   = buttons;
      @(negedge clk);
      check("pulse_end", 32'({sample_valid, serve_pulse}), 32'd0);
      ctrl_read_valid = 1'b0;
   endtask

   initial begin
      logic [8:0]  p;
      logic        s, pa, stl;
      logic [15:0] b;
      bit          ok;
      int          hi;
      int          cnt;

      reset           = 1'b1;
      enable          = 1'b1;
      ctrl_data       = '0;
      ctrl_read_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      check("rst_pos",     32'(paddle_pos),    32'd200);
      check("rst_buttons", 32'(buttons),       32'd0);
      check("rst_flags",   32'({poll_start, sample_valid, serve_pulse, pause, stale}), 32'd0);
      check("rst_tcount",  32'(timeout_count), 32'd0);

      // --- vector table ---
      add(1, mkst(0,0,0,0,40), 300, 204, 0, 0);
      add(1, mkst(0,0,0,0,-128), 0, 185, 0, 0);
      add(0, mkst(0,0,0,0,5),   17, 185, 0, 0);
      add(0, mkst(0,0,0,0,9),   33, 186, 0, 0);
      add(0, mkst(0,0,1,0,0),   20, 188, 0, 0);
      add(0, mkst(0,0,0,1,0),   20, 186, 0, 0);
      add(0, mkst(0,0,1,1,0),   20, 186, 0, 0);
      add(0, mkst(0,0,1,0,3),   20, 188, 0, 0);
      add(0, mkst(0,0,0,1,20),  20, 189, 0, 0);
      // upper saturation: 200 + 14*14 = 396, Up -> 398, +127 -> clamp 400
      for (int k = 1; k <= 14; k++)
         add(k == 1, mkst(0,0,0,0,127), 10 + k, 200 + 14 * k, 0, 0);
      add(0, mkst(0,0,1,0,0),   20, 398, 0, 0);
      add(0, mkst(0,0,0,0,127), 20, 400, 0, 0);
      // lower saturation: 200 - 13*15 = 5, Down -> 3, -100 -> clamp 0
      for (int k = 1; k <= 13; k++)
         add(k == 1, mkst(0,0,0,0,-128), 5 * k, 200 - 15 * k, 0, 0);
      add(0, mkst(0,0,0,1,0),    20, 3, 0, 0);
      add(0, mkst(0,0,0,0,-100), 20, 0, 0, 0);
      add(0, mkst(0,0,0,1,0),    20, 0, 0, 0);
      // button edges
      add(1, mkst(1,0,0,0,0),  20, 200, 1, 0);
      add(0, mkst(1,0,0,0,0),  20, 200, 0, 0);
      add(0, mkst(0,1,0,0,0),  20, 200, 0, 1);
      add(0, mkst(0,0,0,0,40), 20, 200, 0, 1);
      add(0, mkst(1,0,0,0,0),  20, 200, 0, 1);
      add(0, mkst(0,1,0,0,0),  20, 200, 0, 0);
      add(0, mkst(0,0,0,0,40), 20, 204, 0, 0);
      add(0, mkst(1,0,0,0,0),  20, 204, 1, 0);

      for (int i = 0; i < nvec; i++) begin
         if (vecs[i].rst) do_reset();
         do_poll(vecs[i].st, vecs[i].dly, p, s, pa, stl, b);
         check($sformatf("v%0d_pos", i),     32'(p),   32'(vecs[i].pos));
         check($sformatf("v%0d_serve", i),   32'(s),   32'(vecs[i].serve));
         check($sformatf("v%0d_pause", i),   32'(pa),  32'(vecs[i].pause));
         check($sformatf("v%0d_stale", i),   32'(stl), 32'd0);
         check($sformatf("v%0d_buttons", i), 32'(b),   32'(vecs[i].st[31:16]));
         $display("[TB] vec %0d status=%08h pos=%0d serve=%0d pause=%0d",
                  i, vecs[i].st, p, s, pa);
      end

      // --- timeout: no response at all ---
      wait_poll(ok);
      if (ok) begin
         hi = 1;
         for (int k = 1; k < 800; k++) begin
            @(negedge clk);
            if (poll_start) hi++;
         end
         check("stale_before_timeout", 32'(stale), 32'd0);
         @(negedge clk);
         check("stale_at_timeout", 32'(stale), 32'd1);
         check("tcount_after_timeout", 32'(timeout_count), 32'd1);
         check("poll_start_width", 32'(hi), 32'd2);
         $display("[TB] timeout stale=%0d timeout_count=%0d", stale, timeout_count);
      end

      // --- recovery clears stale ---
      do_poll(mkst(0,0,0,0,40), 20, p, s, pa, stl, b);
      check("recover_stale", 32'(stl), 32'd0);
      check("recover_pos",   32'(p),   32'd208);
      check("recover_tcount", 32'(timeout_count), 32'd1);
      $display("[TB] recovery pos=%0d stale=%0d", p, stl);

      // --- response edge while IDLE is ignored ---
      repeat (50) @(negedge clk);
      ctrl_data       = {2'b00, mkst(1,1,0,0,127)};
      ctrl_read_valid = 1'b1;
      cnt = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 2) ctrl_read_valid = 1'b0;
         if (sample_valid) cnt++;
      end
      check("idle_rise_ignored", 32'(cnt), 32'd0);
      check("idle_rise_pos", 32'(paddle_pos), 32'd208);
      $display("[TB] idle response sample_valid_count=%0d pos=%0d", cnt, paddle_pos);

      // --- enable low skips the poll ---
      enable = 1'b0;
      cnt = 0;
      for (int k = 0; k < 1100; k++) begin
         @(negedge clk);
         if (poll_start) cnt++;
      end
      check("disabled_no_poll", 32'(cnt), 32'd0);
      $display("[TB] enable=0 poll_start_cycles=%0d", cnt);
      enable = 1'b1;

      // --- reset in WAIT_RESP abandons the poll ---
      wait_poll(ok);
      repeat (100) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_pos",    32'(paddle_pos),    32'd200);
      check("midreset_tcount", 32'(timeout_count), 32'd0);
      check("midreset_stale",  32'(stale),         32'd0);
      cnt = 0;
      for (int k = 1; k < 1000; k++) begin
         @(negedge clk);
         if (poll_start || timeout_count != 8'd0) cnt++;
      end
      check("midreset_quiet", 32'(cnt), 32'd0);
      @(negedge clk);
      check("midreset_next_poll", 32'(poll_start), 32'd1);
      $display("[TB] reset mid-poll pos=%0d next poll_start=%0d", paddle_pos, poll_start);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
